// File: rtl/fp16_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp16_pkg : shared FP16 constants, accumulator states, LZ helper  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fp16_pkg;

    localparam int          FP16_W    = 16;
    localparam int          FP16_SIGN = 15;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Leading-zero count of a 14-bit value; returns 14 for zero.
    function automatic logic [3:0] lzc14(input logic [13:0] v);
        lzc14 = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) lzc14 = 4'(13 - i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp16_adder : combinational binary16 adder, round-to-nearest-even |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fp16_adder
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic [FP16_W-1:0] sum
);

    logic [15:0] w_big, w_sml;
    logic [4:0]  w_eb, w_es, w_d;
    logic [13:0] w_bx, w_aligned, w_n;
    logic [27:0] w_sh;
    logic [14:0] w_raw, w_pk;
    logic [5:0]  w_e, w_s;
    logic [3:0]  w_lz;
    logic        w_sub, w_inc, w_nan;

    always_comb begin
        // Order operands by magnitude so the small one is the one aligned.
        w_big = (b[14:0] > a[14:0]) ? b : a;
        w_sml = (b[14:0] > a[14:0]) ? a : b;
        w_eb  = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
        w_es  = (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10];
        w_d   = w_eb - w_es;
        w_bx  = {|w_big[14:10], w_big[9:0], 3'b000};
        w_sh  = {{|w_sml[14:10], w_sml[9:0], 3'b000}, 14'd0} >> ((w_d > 5'd14) ? 5'd14 : w_d);
        w_aligned = {w_sh[27:15], w_sh[14] | (|w_sh[13:0])};
        w_sub = w_big[15] ^ w_sml[15];
        w_raw = w_sub ? ({1'b0, w_bx} - {1'b0, w_aligned})
                      : ({1'b0, w_bx} + {1'b0, w_aligned});

        w_e  = {1'b0, w_eb};
        w_lz = lzc14(w_raw[13:0]);
        w_s  = 6'd0;
        if (w_raw[14]) begin
            w_n = {w_raw[14:2], w_raw[1] | w_raw[0]};
            w_e = w_e + 6'd1;
        end else begin
            // Left shift is capped so that tiny results land as subnormals.
            w_s = ({2'b00, w_lz} > (w_e - 6'd1)) ? (w_e - 6'd1) : {2'b00, w_lz};
            w_n = w_raw[13:0] << w_s;
            w_e = w_e - w_s;
        end

        w_inc = w_n[2] & (w_n[3] | w_n[1] | w_n[0]);
        w_pk  = {(w_n[13] ? w_e[4:0] : 5'd0), w_n[12:3]} + {14'd0, w_inc};
        w_nan = ((a[14:10] == 5'h1F) && (a[9:0] != 10'd0)) ||
                ((b[14:10] == 5'h1F) && (b[9:0] != 10'd0));

        if (w_nan)
            sum = FP16_QNAN;
        else if (w_big[14:10] == 5'h1F)
            sum = (w_sml[14:10] == 5'h1F && w_sub) ? FP16_QNAN : w_big;
        else if (w_raw == 15'd0)
            sum = {w_big[15] & ~w_sub, 15'd0};
        else if (w_e >= 6'd31)
            sum = {w_big[15], 5'h1F, 10'd0};
        else
            sum = {w_big[15], w_pk};
    end

endmodule
`default_nettype wire

// File: rtl/fp16_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp16_accumulator : streaming FP16 window sum with valid/ready    |
// | Option: FP16_ACC_RELU_EN clamps negative-signed results to +0.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP16_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count
);

    acc_state_t        r_state, w_next_state;
    logic [FP16_W-1:0] r_acc, w_sum, w_next_acc, w_out_val;
    logic [CNT_W-1:0]  r_cnt, w_next_cnt;
    logic              w_accept;

    fp16_adder u_adder (
        .a   (r_acc),
        .b   (in_data),
        .sum (w_sum)
    );

    assign in_ready = (r_state != DONE);
    assign w_accept = in_valid & in_ready;

    // The first element of a window bypasses the adder so -0 and NaN survive.
    assign w_next_acc = (r_state == IDLE) ? in_data : w_sum;
    assign w_next_cnt = (r_state == IDLE) ? CNT_W'(1)
                      : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));

`ifdef FP16_ACC_RELU_EN
    assign w_out_val = w_next_acc[FP16_SIGN] ? FP16_ZERO : w_next_acc;
`else
    assign w_out_val = w_next_acc;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = in_last ? DONE : ACCUM;
            ACCUM:   if (w_accept && in_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= FP16_ZERO;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= FP16_ZERO;
            out_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_acc <= w_next_acc;
                r_cnt <= w_next_cnt;
                if (in_last) begin
                    out_data  <= w_out_val;
                    out_count <= w_next_cnt;
                    out_valid <= 1'b1;
                end
            end else if (r_state == DONE && out_ready) begin
                out_valid <= 1'b0;
                r_acc     <= FP16_ZERO;
                r_cnt     <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fp16_accumulator : directed vectors for fp16_accumulator      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fp16_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    logic        v2 = 1'b0, l2 = 1'b0, r2 = 1'b0;
    logic [15:0] d2 = 16'h0000;
    logic        rdy2, vld2;
    logic [15:0] od2;
    logic [1:0]  oc2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp16_accumulator #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    fp16_accumulator #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_last(l2),
        .out_valid(vld2), .out_ready(r2), .out_data(od2), .out_count(oc2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one element for one edge; inputs change 1 time unit after posedge.
    task automatic push(input logic [15:0] d, input logic last);
        check("in_ready_before_push", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pop_valid_low", {31'd0, out_valid}, 32'd0);
        check("pop_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic expect_result(input string tag, input logic [15:0] d, input logic [7:0] c);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
        check({tag, "_count"}, {24'd0, out_count}, {24'd0, c});
        check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    endtask

    logic [15:0] neg_zero_exp, neg_half_exp;

    initial begin
`ifdef FP16_ACC_RELU_EN
        neg_zero_exp = 16'h0000;
        neg_half_exp = 16'h0000;
`else
        neg_zero_exp = 16'h8000;
        neg_half_exp = 16'hB800;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_count", {24'd0, out_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1 + 2 + 3 with an idle gap mid-window
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("gap_no_valid", {31'd0, out_valid}, 32'd0);
        push(16'h4200, 1'b1);
        expect_result("sum123", 16'h4600, 8'd3);
        pop();

        // Single-element windows, including negative zero
        push(16'h3C00, 1'b1);
        expect_result("single_one", 16'h3C00, 8'd1);
        pop();
        push(16'h8000, 1'b1);
        expect_result("single_negzero", neg_zero_exp, 8'd1);
        pop();

        // Backpressure: held result, offered input must not be taken
        push(16'h4200, 1'b1);
        in_valid = 1'b1; in_data = 16'h7C00; in_last = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        expect_result("stall", 16'h4200, 8'd1);
        in_valid = 1'b0; in_last = 1'b0;
        pop();
        push(16'h4000, 1'b0);
        push(16'h4000, 1'b1);
        expect_result("sum22", 16'h4400, 8'd2);
        pop();

        // -1 + 0.5
        push(16'hBC00, 1'b0);
        push(16'h3800, 1'b1);
        expect_result("neg_half", neg_half_exp, 8'd2);
        pop();

        // Reset mid-window discards the partial sum
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        push(16'h3C00, 1'b1);
        expect_result("after_rst", 16'h3C00, 8'd1);

        // Reset while in DONE clears outputs
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("donerst_valid", {31'd0, out_valid}, 32'd0);
        check("donerst_data", {16'd0, out_data}, 32'd0);
        check("donerst_count", {24'd0, out_count}, 32'd0);

        // Count saturation on the narrow instance: 5 x 1.0
        for (int i = 0; i < 5; i++) begin
            check("sat_in_ready", {31'd0, rdy2}, 32'd1);
            v2 = 1'b1; d2 = 16'h3C00; l2 = (i == 4);
            @(posedge clk); #1;
        end
        v2 = 1'b0; l2 = 1'b0;
        check("sat_valid", {31'd0, vld2}, 32'd1);
        check("sat_data", {16'd0, od2}, 32'h0000_4500);
        check("sat_count", {30'd0, oc2}, 32'd3);
        r2 = 1'b1;
        @(posedge clk); #1 r2 = 1'b0;
        check("sat_pop_valid", {31'd0, vld2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
